fan_status_reporter: RTL and testbench

- Periodically snapshots fan status and formats it into a fixed 32-character ASCII status line.
- Presents the line to the UART string transmitter (string / string_len / send_enable interface) that sits directly downstream.
- Inputs come from the fan controller, fan timer and DHT11 sensor path.
- Provides periodic reports plus on-demand reports, with a guard interval so the transmitter is never re-triggered mid-string.

---
 rtl/fan_status_reporter_pkg.sv | 28 ++
 rtl/fan_status_reporter_bin2dec_seq.sv | 39 +++
 rtl/fan_status_reporter.sv | 109 ++++++++++
 tb/tb_fan_status_reporter.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/fan_status_reporter_pkg.sv
// fan_status_reporter_pkg: shared ASCII constants, FSM encoding and character helpers
package fan_status_reporter_pkg;

   localparam logic [7:0] ASC_0      = 8'h30;
   localparam logic [7:0] ASC_Q      = 8'h3f;
   localparam logic [7:0] ASC_DASH   = 8'h2d;
   localparam logic [7:0] ASC_DOLLAR = 8'h24;
   localparam logic [7:0] ASC_CR     = 8'h0d;
   localparam logic [7:0] ASC_LF     = 8'h0a;
   localparam logic [7:0] ASC_SP     = 8'h20;
   localparam logic [5:0] LINE_LEN   = 6'd32;

   typedef enum logic [2:0] {IDLE, SNAP, CONV_T, CONV_H, BUILD, SEND} state_t;

   // Index of the single set bit (0..3) as ASCII; anything else is '?'
   function automatic logic [7:0] onehot_char(input logic [7:0] v);
      return v == 8'h01 ? ASC_0 :
             v == 8'h02 ? ASC_0 + 8'd1 :
             v == 8'h04 ? ASC_0 + 8'd2 :
             v == 8'h08 ? ASC_0 + 8'd3 : ASC_Q;
   endfunction

   // Decimal digit as ASCII; non-decimal nibbles are '?'
   function automatic logic [7:0] dec_char(input logic [3:0] n);
      return n > 4'd9 ? ASC_Q : ASC_0 + {4'h0, n};
   endfunction

endpackage

// File: rtl/fan_status_reporter_bin2dec_seq.sv
// bin2dec_seq: sequential 8-bit to two-digit decimal converter by repeated subtract-10
module bin2dec_seq (
   input  logic       clk,
   input  logic       reset_p,
   input  logic       start,
   input  logic [7:0] value,
   output logic       done,
   output logic [3:0] tens,
   output logic [3:0] ones,
   output logic       ovf
);

   logic [7:0] rem;
   logic       run;

   assign done = run && (ovf || rem < 8'd10);
   assign ones = rem[3:0];

   // Load on start, then peel off one ten per cycle until the remainder is a single digit
   always_ff @(posedge clk) begin
      if (reset_p) begin
         run  <= 1'b0;
         rem  <= '0;
         tens <= '0;
         ovf  <= 1'b0;
      end else if (start) begin
         run  <= 1'b1;
         rem  <= value;
         tens <= '0;
         ovf  <= value > 8'd99;
      end else if (done) begin
         run  <= 1'b0;
      end else if (run) begin
         rem  <= rem - 8'd10;
         tens <= tens + 4'd1;
      end
   end

endmodule

// File: rtl/fan_status_reporter.sv
// fan_status_reporter: periodic/on-demand fan status line builder for the UART string transmitter
module fan_status_reporter
   import fan_status_reporter_pkg::*;
#(
   parameter int SYS_FREQ  = 125,
   parameter int REPORT_US = 1_000_000,
   parameter int GUARD_US  = 5_000
) (
   input  logic         clk,
   input  logic         reset_p,
   input  logic [7:0]   fan_speed,
   input  logic [3:0]   fan_timer_state,
   input  logic [19:0]  cur_time,
   input  logic [7:0]   temperature,
   input  logic [7:0]   humidity,
   input  logic         force_send,
   output logic [255:0] string_data,
   output logic [5:0]   string_len,
   output logic         send_enable,
   output logic         busy
);

   localparam int PER = REPORT_US * SYS_FREQ;
   localparam int GRD = GUARD_US * SYS_FREQ;
   localparam int PW  = $clog2(PER);
   localparam int GW  = $clog2(GRD);

   state_t        state, next;
   logic [PW-1:0] per_cnt;
   logic [GW-1:0] grd_cnt;
   logic          tick, grd_exp, pend, start, done, ovf;
   logic [3:0]    tens, ones;
   logic [7:0]    fan_q, hum_q;
   logic [3:0]    tmr_q;
   logic [19:0]   time_q;
   logic [15:0]   tt, hh;

   assign tick        = per_cnt == PW'(PER - 1);
   assign grd_exp     = grd_cnt == GW'(GRD - 1);
   assign send_enable = state == SEND;
   assign busy        = state != IDLE;
   assign string_len  = LINE_LEN;

   bin2dec_seq conv (
      .clk     (clk),
      .reset_p (reset_p),
      .start   (start),
      .value   (state == SNAP ? temperature : hum_q),
      .done    (done),
      .tens    (tens),
      .ones    (ones),
      .ovf     (ovf)
   );

   // Request tracking: period tick, guard window and a single sticky pending flag
   always_ff @(posedge clk) begin
      if (reset_p) begin
         state   <= IDLE;
         pend    <= 1'b0;
         per_cnt <= '0;
         grd_cnt <= GW'(GRD - 1);
      end else begin
         state   <= next;
         pend    <= (pend && state != SNAP) || tick || force_send;
         per_cnt <= tick ? '0 : per_cnt + 1'b1;
         grd_cnt <= state == SEND ? '0 : grd_exp ? grd_cnt : grd_cnt + 1'b1;
      end
   end

   // Snapshot and digit capture so late input changes cannot touch the in-flight line
   always_ff @(posedge clk) begin
      if (state == SNAP) begin
         fan_q  <= fan_speed;
         tmr_q  <= fan_timer_state;
         time_q <= cur_time;
         hum_q  <= humidity;
      end
      if (state == CONV_T && done) tt <= ovf ? {ASC_DASH, ASC_DASH} : {dec_char(tens), dec_char(ones)};
      if (state == CONV_H && done) hh <= ovf ? {ASC_DASH, ASC_DASH} : {dec_char(tens), dec_char(ones)};
   end

   // The line only changes in BUILD, so it is stable across the SEND cycle
   always_ff @(posedge clk) begin
      if (reset_p)
         string_data <= '0;
      else if (state == BUILD)
         string_data <= {ASC_DOLLAR, "FAN=", onehot_char(fan_q), ASC_SP,
                         "TMR=", onehot_char({4'h0, tmr_q}), ASC_SP,
                         dec_char(time_q[19:16]), ":", dec_char(time_q[15:12]), dec_char(time_q[11:8]),
                         ":", dec_char(time_q[7:4]), dec_char(time_q[3:0]), ASC_SP,
                         "T", tt, "C", ASC_SP, "H", hh, "%", ASC_CR, ASC_LF};
   end

   // Next state and converter start; temperature starts in SNAP, humidity as temperature finishes
   always_comb begin
      next  = state;
      start = 1'b0;
      unique case (state)
         IDLE:    if (pend && grd_exp) next = SNAP;
         SNAP:    begin start = 1'b1; next = CONV_T; end
         CONV_T:  if (done) begin start = 1'b1; next = CONV_H; end
         CONV_H:  if (done) next = BUILD;
         BUILD:   next = SEND;
         SEND:    next = IDLE;
         default: next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_fan_status_reporter.sv
// tb_fan_status_reporter: directed vectors with hand-computed lines and cycle counts
module tb_fan_status_reporter;

   logic         clk = 1'b0, reset_p = 1'b1, force_send = 1'b0;
   logic [7:0]   fan_speed = '0, temperature = '0, humidity = '0;
   logic [3:0]   fan_timer_state = '0;
   logic [19:0]  cur_time = '0;
   logic [255:0] string_data;
   logic [5:0]   string_len;
   logic         send_enable, busy;
   int           checks = 0, errors = 0;
   int           n, bc, cnt;
   logic [255:0] line_a, line_b, line_c, line_d;

   always #4 clk = ~clk;

   fan_status_reporter #(.SYS_FREQ(125), .REPORT_US(100), .GUARD_US(10)) dut (
      .clk             (clk),
      .reset_p         (reset_p),
      .fan_speed       (fan_speed),
      .fan_timer_state (fan_timer_state),
      .cur_time        (cur_time),
      .temperature     (temperature),
      .humidity        (humidity),
      .force_send      (force_send),
      .string_data     (string_data),
      .string_len      (string_len),
      .send_enable     (send_enable),
      .busy            (busy)
   );

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic set_in(input logic [7:0] f, input logic [3:0] r, input logic [19:0] t,
                         input logic [7:0] te, input logic [7:0] hu);
      fan_speed = f; fan_timer_state = r; cur_time = t; temperature = te; humidity = hu;
   endtask

   // Counts rising edges until send_enable is seen at a falling edge; also counts busy cycles
   task automatic wait_send(input int bound, output int cyc, output int bcy);
      cyc = 0; bcy = 0;
      do begin
         @(posedge clk); cyc++;
         @(negedge clk); force_send = 1'b0;
         if (busy) bcy++;
      end while (!send_enable && cyc < bound);
      check("send_seen", send_enable, 1'b1);
   endtask

   initial begin
      line_a = {"$FAN=2 TMR=1 1:23:45 T25C H60%", 8'h0d, 8'h0a};
      line_b = {"$FAN=? TMR=3 9:5?:07 T--C H07%", 8'h0d, 8'h0a};
      line_c = {"$FAN=0 TMR=0 0:00:00 T00C H99%", 8'h0d, 8'h0a};
      line_d = {"$FAN=2 TMR=1 1:23:45 T--C H00%", 8'h0d, 8'h0a};
      repeat (3) @(negedge clk);
      reset_p = 1'b0;
      check("rst_string", string_data, '0);
      check("rst_len", string_len, 32);
      check("rst_send", send_enable, 1'b0);
      check("rst_busy", busy, 1'b0);

      set_in(8'b0000_0100, 4'b0010, 20'h1_23_45, 8'd25, 8'd60);
      force_send = 1'b1;
      wait_send(40, n, bc);
      check("a_latency", n, 14);
      check("a_busy_cycles", bc, 13);
      check("a_line", string_data, line_a);
      check("a_len", string_len, 32);
      @(negedge clk);
      check("a_send_one_cycle", send_enable, 1'b0);
      check("a_busy_drop", busy, 1'b0);

      repeat (99) @(negedge clk);
      set_in(8'b0000_0110, 4'b1000, 20'h9_5A_07, 8'd150, 8'd7);
      force_send = 1'b1;
      n = 100;
      while (n < 2000) begin
         @(posedge clk); n++;
         @(negedge clk); force_send = 1'b0;
         if (n == 1253) begin
            check("b_busy_at_force", busy, 1'b1);
            set_in(8'b0000_0001, 4'b0001, 20'h0_00_00, 8'd0, 8'd99);
            force_send = 1'b1;
         end
         if (send_enable) break;
      end
      check("b_guard_spacing", n, 1255);
      check("b_line", string_data, line_b);

      wait_send(2000, n, bc);
      check("c_guard_spacing", n, 1264);
      check("c_line", string_data, line_c);
      cnt = 0;
      repeat (2000) begin
         @(negedge clk);
         if (send_enable) cnt++;
      end
      check("c_no_extra", cnt, 0);

      set_in(8'b0000_0100, 4'b0010, 20'h1_23_45, 8'd100, 8'd0);
      force_send = 1'b1;
      wait_send(40, n, bc);
      check("d_latency", n, 6);
      check("d_line", string_data, line_d);

      repeat (1300) @(negedge clk);
      set_in(8'b0000_0001, 4'b0001, 20'h0_00_00, 8'd0, 8'd99);
      force_send = 1'b1;
      repeat (6) begin
         @(posedge clk);
         @(negedge clk); force_send = 1'b0;
      end
      check("r_busy_in_conv", busy, 1'b1);
      reset_p = 1'b1;
      @(negedge clk);
      reset_p = 1'b0;
      check("r_string", string_data, '0);
      check("r_busy", busy, 1'b0);
      check("r_send", send_enable, 1'b0);
      cnt = 0;
      repeat (40) begin
         @(negedge clk);
         if (send_enable) cnt++;
      end
      check("r_no_send", cnt, 0);
      set_in(8'b0000_0100, 4'b0010, 20'h1_23_45, 8'd25, 8'd60);
      force_send = 1'b1;
      wait_send(40, n, bc);
      check("r_after_latency", n, 14);
      check("r_after_line", string_data, line_a);

      reset_p = 1'b1;
      @(negedge clk);
      reset_p = 1'b0;
      wait_send(13000, n, bc);
      wait_send(13000, n, bc);
      check("p_period_1", n, 12500);
      wait_send(13000, n, bc);
      check("p_period_2", n, 12500);
      check("p_line", string_data, line_a);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
